// File: rtl/tail_light_sequencer_if.sv
// Tail-light sequencer bundle: dashboard requests in, lamp drives and status out.
// Ports: left/right/hazard/brake requests (level, asynchronous to clk);
//        L1..L3 / R1..R3 lamp drives (1 = innermost), busy, 2-bit mode.
interface tail_light_sequencer_if;
    logic       left;
    logic       right;
    logic       hazard;
    logic       brake;
    logic       L1;
    logic       L2;
    logic       L3;
    logic       R1;
    logic       R2;
    logic       R3;
    logic       busy;
    logic [1:0] mode;

    // Dashboard side: drives requests, observes lamps and status.
    modport master (
        output left, right, hazard, brake,
        input  L1, L2, L3, R1, R2, R3, busy, mode
    );

    // Sequencer side.
    modport slave (
        input  left, right, hazard, brake,
        output L1, L2, L3, R1, R2, R3, busy, mode
    );
endinterface

// File: rtl/tail_light_sequencer.sv
// Turn-signal / hazard / brake sequencer for a six-lamp tail-light cluster.
// Latency: requests reach the FSM after 2 clocks; lamps lag mode/phase by 1 clock.
// Backpressure: none; free-running, paced by an internal prescaler tick.
// Ports: clk, rst (async active-low), tl (slave modport: requests in, lamps/busy/mode out).
module tail_light_sequencer #(
    parameter int TICK_DIV = 4,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    tail_light_sequencer_if.slave tl
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2,
        HAZ   = 2'd3
    } mode_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    // Bit order in the synchroniser vectors: {brake, hazard, right, left}.
    logic [3:0]       sync1_q;
    logic [3:0]       sync2_q;
    logic             left_s;
    logic             right_s;
    logic             hazard_s;
    logic             brake_s;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick;

    mode_e            mode_q;
    mode_e            mode_d;
    mode_e            arb_mode;
    logic [1:0]       phase_q;
    logic [1:0]       phase_d;

    // Lamp vector order: {L3, L2, L1, R1, R2, R3}.
    logic [5:0]       lamp_q;
    logic [5:0]       lamp_d;

    assign left_s   = sync2_q[0];
    assign right_s  = sync2_q[1];
    assign hazard_s = sync2_q[2];
    assign brake_s  = sync2_q[3];

    // Both turn requests at once are treated as a hazard request.
    function automatic mode_e arbitrate(input logic l, input logic r, input logic h);
        if (h || (l && r)) begin
            return HAZ;
        end else if (l) begin
            return LEFT;
        end else if (r) begin
            return RIGHT;
        end
        return IDLE;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cnt_q   <= '0;
            mode_q  <= IDLE;
            phase_q <= 2'd0;
            lamp_q  <= '0;
        end else begin
            sync1_q <= {tl.brake, tl.hazard, tl.right, tl.left};
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            phase_q <= phase_d;
            lamp_q  <= lamp_d;
        end
    end

    always_comb begin
        tick  = (cnt_q == CNT_LAST);
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    // Mode/phase next state; only advances on a prescaler tick.
    always_comb begin
        mode_d   = mode_q;
        phase_d  = phase_q;
        arb_mode = arbitrate(left_s, right_s, hazard_s);
        if (tick) begin
            unique case (mode_q)
                IDLE: begin
                    mode_d  = arb_mode;
                    phase_d = (arb_mode != IDLE) ? 2'd1 : 2'd0;
                end
                LEFT, RIGHT: begin
                    if (hazard_s) begin
                        // Hazard preempts a running turn sequence immediately.
                        mode_d  = HAZ;
                        phase_d = 2'd1;
                    end else if (phase_q == 2'd1 || phase_q == 2'd2) begin
                        phase_d = phase_q + 2'd1;
                    end else if (phase_q == 2'd3) begin
                        phase_d = 2'd0;
                    end else begin
                        // Direction changes and releases only land at phase 0.
                        mode_d  = arb_mode;
                        phase_d = (arb_mode != IDLE) ? 2'd1 : 2'd0;
                    end
                end
                HAZ: begin
                    if (phase_q == 2'd1) begin
                        phase_d = 2'd0;
                    end else begin
                        mode_d  = arb_mode;
                        phase_d = (arb_mode != IDLE) ? 2'd1 : 2'd0;
                    end
                end
                default: begin
                    mode_d  = IDLE;
                    phase_d = 2'd0;
                end
            endcase
        end
    end

    // Lamp decode of the current state; registered, so lamps trail mode/phase by one clock.
    always_comb begin
        lamp_d = {6{brake_s}};
        unique case (mode_q)
            LEFT: begin
                unique case (phase_q)
                    2'd1:    lamp_d[5:3] = 3'b001;
                    2'd2:    lamp_d[5:3] = 3'b011;
                    2'd3:    lamp_d[5:3] = 3'b111;
                    default: lamp_d[5:3] = 3'b000;
                endcase
            end
            RIGHT: begin
                unique case (phase_q)
                    2'd1:    lamp_d[2:0] = 3'b100;
                    2'd2:    lamp_d[2:0] = 3'b110;
                    2'd3:    lamp_d[2:0] = 3'b111;
                    default: lamp_d[2:0] = 3'b000;
                endcase
            end
            HAZ: begin
                // Brake is deliberately ignored while flashing hazards.
                lamp_d = {6{phase_q == 2'd1}};
            end
            default: begin
                lamp_d = {6{brake_s}};
            end
        endcase
    end

    assign tl.L3   = lamp_q[5];
    assign tl.L2   = lamp_q[4];
    assign tl.L1   = lamp_q[3];
    assign tl.R1   = lamp_q[2];
    assign tl.R2   = lamp_q[1];
    assign tl.R3   = lamp_q[0];
    assign tl.busy = (mode_q != IDLE);
    assign tl.mode = mode_q;

endmodule
